// File: rtl/rps_pkg.sv
// rtl/rps_pkg.sv - shared types and helpers for the rock-paper-scissors round controller
package rps_pkg;

    typedef enum logic [2:0] {
        MV_NONE     = 3'd0,
        MV_ROCK     = 3'd1,
        MV_PAPER    = 3'd2,
        MV_SCISSORS = 3'd3,
        MV_INVALID  = 3'd4
    } move_t;

    typedef enum logic [1:0] {
        RES_NONE  = 2'b00,
        RES_A_WIN = 2'b01,
        RES_B_WIN = 2'b10,
        RES_TIE   = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_B = 2'd1,
        ST_SHOW   = 2'd2
    } round_state_t;

    function automatic move_t decode_move(input logic [2:0] bits);
        move_t m;
        case (bits)
            3'b100:  m = MV_ROCK;
            3'b010:  m = MV_PAPER;
            3'b001:  m = MV_SCISSORS;
            default: m = MV_INVALID;
        endcase
        return m;
    endfunction

    function automatic result_t score(input move_t a, input move_t b);
        result_t r;
        if (a == b) begin
            r = RES_TIE;
        end else if ((a == MV_ROCK     && b == MV_SCISSORS) ||
                     (a == MV_SCISSORS && b == MV_PAPER)    ||
                     (a == MV_PAPER    && b == MV_ROCK)) begin
            r = RES_A_WIN;
        end else begin
            r = RES_B_WIN;
        end
        return r;
    endfunction

    // LED order is {rock,paper,scissors}
    function automatic logic [2:0] move_leds(input move_t m);
        logic [2:0] l;
        case (m)
            MV_ROCK:     l = 3'b100;
            MV_PAPER:    l = 3'b010;
            MV_SCISSORS: l = 3'b001;
            default:     l = 3'b000;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/cs_sync_edge.sv
// rtl/cs_sync_edge.sv - chip-select synchroniser with registered falling-edge (end of frame) pulse
module cs_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_cs,
    output logic o_frame_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_cs_s_d;
    logic                   r_pulse;
    logic                   w_cs_s;

    assign w_cs_s        = r_sync[SYNC_STAGES-1];
    assign o_frame_pulse = r_pulse;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync   <= '0;
            r_cs_s_d <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_cs};
            r_cs_s_d <= w_cs_s;
            r_pulse  <= ~w_cs_s & r_cs_s_d;
        end
    end

endmodule

// File: rtl/rps_round_ctrl.sv
// rtl/rps_round_ctrl.sv - captures SPI move bytes, sequences one round, drives registered LED outputs
module rps_round_ctrl
    import rps_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 48_000_000,
    parameter int DISPLAY_CYCLES = 24_000_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic [7:0] sig,
    output logic [2:0] led_a,
    output logic [2:0] led_b,
    output logic [1:0] result,
    output logic       busy,
    output logic       err,
    output logic       overrun
);

    localparam int MAX_CYC = (TIMEOUT_CYCLES > DISPLAY_CYCLES) ? TIMEOUT_CYCLES : DISPLAY_CYCLES;
    localparam int CW      = $clog2(MAX_CYC);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] DSP_LAST = CW'(DISPLAY_CYCLES - 1);

    logic         w_frame_pulse;
    logic [7:0]   r_byte_q;
    logic         r_byte_v;
    move_t        w_move;
    logic         w_unused_bits;

    round_state_t r_state;
    logic [CW-1:0] r_tmo;
    logic [CW-1:0] r_cnt;
    move_t        r_move_a;
    move_t        r_move_b;
    result_t      r_res;
    logic         r_err;
    logic         r_ovr;

    cs_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cs_sync (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_cs          (cs),
        .o_frame_pulse (w_frame_pulse)
    );

    assign w_move        = decode_move(r_byte_q[7:5]);
    assign w_unused_bits = ^r_byte_q[4:0];

    // sck has stopped before cs falls, so sig is stable when the pulse arrives
    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_q <= 8'h00;
            r_byte_v <= 1'b0;
        end else begin
            r_byte_v <= w_frame_pulse;
            if (w_frame_pulse) begin
                r_byte_q <= sig;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_tmo    <= '0;
            r_cnt    <= '0;
            r_move_a <= MV_NONE;
            r_move_b <= MV_NONE;
            r_res    <= RES_NONE;
            r_err    <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_byte_v) begin
                        if (w_move != MV_INVALID) begin
                            r_move_a <= w_move;
                            r_move_b <= MV_NONE;
                            r_res    <= RES_NONE;
                            r_err    <= 1'b0;
                            r_tmo    <= '0;
                            r_state  <= ST_WAIT_B;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_WAIT_B: begin
                    r_tmo <= r_tmo + CW'(1);
                    // a valid move B takes priority over an expiring timeout
                    if (r_byte_v && w_move != MV_INVALID) begin
                        r_move_b <= w_move;
                        r_res    <= score(r_move_a, w_move);
                        r_cnt    <= '0;
                        r_state  <= ST_SHOW;
                    end else begin
                        if (r_byte_v) begin
                            r_err <= 1'b1;
                        end
                        if (r_tmo == TMO_LAST) begin
                            r_err    <= 1'b1;
                            r_move_a <= MV_NONE;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                ST_SHOW: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_byte_v) begin
                        r_ovr <= 1'b1;
                    end
                    if (r_cnt == DSP_LAST) begin
                        r_move_a <= MV_NONE;
                        r_move_b <= MV_NONE;
                        r_res    <= RES_NONE;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_a   <= 3'b000;
            led_b   <= 3'b000;
            result  <= 2'b00;
            busy    <= 1'b0;
            err     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            led_a   <= move_leds(r_move_a);
            led_b   <= move_leds(r_move_b);
            result  <= r_res;
            busy    <= (r_state != ST_IDLE);
            err     <= r_err;
            overrun <= r_ovr;
        end
    end

endmodule
